// File: rtl/ex_mem_stage_reg_pkg.sv
// Shared constants and the stage-select encoding for the EX/MEM pipeline register.
// Macro EX_MEM_LSU_EN (optional) adds the load/store sideband fields.
package ex_mem_stage_reg_pkg;

  localparam logic       RST_ACTIVE   = 1'b0;
  localparam logic [4:0] NOP_REG_ADDR = 5'd0;
  localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;
  localparam logic [7:0] NOP_ALUOP    = 8'h00;
  localparam logic       WRITE_EN     = 1'b1;
  localparam logic       WRITE_DIS    = 1'b0;

  // One-hot update select shared by every field register of the stage.
  typedef enum logic [3:0] {
    SEL_RESET  = 4'b0001,
    SEL_BUBBLE = 4'b0010,
    SEL_HOLD   = 4'b0100,
    SEL_LOAD   = 4'b1000
  } stage_sel_e;

endpackage

// File: rtl/ex_mem_stage_reg_if.sv
// EX-to-MEM bus: EX results in, registered MEM view and multi-cycle feedback out.
// Macro EX_MEM_LSU_EN adds the aluop/address/store-data sideband.
interface ex_mem_stage_reg_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 2,
  parameter int ALUOP_W    = 8
);
  logic [REG_ADDR_W-1:0] ex_wd;
  logic                  ex_wreg;
  logic [DATA_W-1:0]     ex_wdata;
  logic                  ex_whilo;
  logic [DATA_W-1:0]     ex_hi;
  logic [DATA_W-1:0]     ex_lo;
  logic [2*DATA_W-1:0]   hilo_temp_i;
  logic [CNT_W-1:0]      cnt_i;
  logic [REG_ADDR_W-1:0] mem_wd;
  logic                  mem_wreg;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_whilo;
  logic [DATA_W-1:0]     mem_hi;
  logic [DATA_W-1:0]     mem_lo;
  logic [2*DATA_W-1:0]   hilo_temp_o;
  logic [CNT_W-1:0]      cnt_o;
  logic                  mem_valid;
`ifdef EX_MEM_LSU_EN
  logic [ALUOP_W-1:0]    ex_aluop;
  logic [DATA_W-1:0]     ex_mem_addr;
  logic [DATA_W-1:0]     ex_reg2;
  logic [ALUOP_W-1:0]    mem_aluop;
  logic [DATA_W-1:0]     mem_mem_addr;
  logic [DATA_W-1:0]     mem_reg2;
`endif

  modport master (
`ifdef EX_MEM_LSU_EN
    output ex_aluop, ex_mem_addr, ex_reg2,
    input  mem_aluop, mem_mem_addr, mem_reg2,
`endif
    output ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, hilo_temp_i, cnt_i,
    input  mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
    input  hilo_temp_o, cnt_o, mem_valid
  );

  modport slave (
`ifdef EX_MEM_LSU_EN
    input  ex_aluop, ex_mem_addr, ex_reg2,
    output mem_aluop, mem_mem_addr, mem_reg2,
`endif
    input  ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, hilo_temp_i, cnt_i,
    output mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
    output hilo_temp_o, cnt_o, mem_valid
  );
endinterface

// File: rtl/ex_mem_stage_reg_stage_ctl.sv
// Decodes reset/flush/stall into the one-hot update select for the EX/MEM register.
module ex_mem_stage_reg_stage_ctl
  import ex_mem_stage_reg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       stall_ex,
  input  logic       stall_mem,
  output stage_sel_e o_sel
);

  always_comb begin
    // NOTE: assign a default first so every path drives o_sel and no latch is inferred.
    o_sel = SEL_LOAD;
    if (rst == RST_ACTIVE || flush) begin
      o_sel = SEL_RESET;
    end else if (stall_ex && !stall_mem) begin
      o_sel = SEL_BUBBLE;
    end else if (stall_ex && stall_mem) begin
      o_sel = SEL_HOLD;
    end
  end

  // A MEM stall without an EX stall never comes from the stall controllers; it loads.
  a_no_mem_only_stall: assert property (
    @(posedge clk) disable iff (rst == RST_ACTIVE) !(!stall_ex && stall_mem)
  );

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register with stall, bubble, flush and madd/msub feedback.
// Macro EX_MEM_LSU_EN adds the aluop/address/store-data sideband fields.
module ex_mem_stage_reg
  import ex_mem_stage_reg_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 2,
  parameter int ALUOP_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_ex,
  input  logic               stall_mem,
  input  logic               flush,
  ex_mem_stage_reg_if.slave  bus
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] wd;
    logic                  wreg;
    logic [DATA_W-1:0]     wdata;
    logic                  whilo;
    logic [DATA_W-1:0]     hi;
    logic [DATA_W-1:0]     lo;
`ifdef EX_MEM_LSU_EN
    logic [ALUOP_W-1:0]    aluop;
    logic [DATA_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     reg2;
`endif
  } stage_t;

  stage_sel_e          w_sel;
  stage_t              w_ex;
  stage_t              w_nop;
  stage_t              r_stage;
  logic                r_valid;
  logic [2*DATA_W-1:0] r_hilo_temp;
  logic [CNT_W-1:0]    r_cnt;

  ex_mem_stage_reg_stage_ctl u_stage_ctl (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .stall_ex  (stall_ex),
    .stall_mem (stall_mem),
    .o_sel     (w_sel)
  );

  always_comb begin
    w_ex.wd    = bus.ex_wd;
    w_ex.wreg  = bus.ex_wreg;
    w_ex.wdata = bus.ex_wdata;
    w_ex.whilo = bus.ex_whilo;
    w_ex.hi    = bus.ex_hi;
    w_ex.lo    = bus.ex_lo;
`ifdef EX_MEM_LSU_EN
    w_ex.aluop    = bus.ex_aluop;
    w_ex.mem_addr = bus.ex_mem_addr;
    w_ex.reg2     = bus.ex_reg2;
`endif
  end

  // A bubble is a NOP: no write enables, register 0, zero data.
  always_comb begin
    w_nop.wd    = REG_ADDR_W'(NOP_REG_ADDR);
    w_nop.wreg  = WRITE_DIS;
    w_nop.wdata = DATA_W'(ZERO_WORD);
    w_nop.whilo = WRITE_DIS;
    w_nop.hi    = DATA_W'(ZERO_WORD);
    w_nop.lo    = DATA_W'(ZERO_WORD);
`ifdef EX_MEM_LSU_EN
    w_nop.aluop    = ALUOP_W'(NOP_ALUOP);
    w_nop.mem_addr = DATA_W'(ZERO_WORD);
    w_nop.reg2     = DATA_W'(ZERO_WORD);
`endif
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    unique case (w_sel)
      SEL_BUBBLE: begin
        r_stage     <= w_nop;
        r_valid     <= 1'b0;
        r_hilo_temp <= bus.hilo_temp_i;
        r_cnt       <= bus.cnt_i;
      end
      SEL_HOLD: begin
        r_stage     <= r_stage;
        r_valid     <= r_valid;
        r_hilo_temp <= r_hilo_temp;
        r_cnt       <= r_cnt;
      end
      SEL_LOAD: begin
        r_stage     <= w_ex;
        r_valid     <= WRITE_EN;
        r_hilo_temp <= '0;
        r_cnt       <= '0;
      end
      default: begin
        // Reset and flush both squash the entry and any partial madd/msub result.
        r_stage     <= w_nop;
        r_valid     <= 1'b0;
        r_hilo_temp <= '0;
        r_cnt       <= '0;
      end
    endcase
  end

  assign bus.mem_wd      = r_stage.wd;
  assign bus.mem_wreg    = r_stage.wreg;
  assign bus.mem_wdata   = r_stage.wdata;
  assign bus.mem_whilo   = r_stage.whilo;
  assign bus.mem_hi      = r_stage.hi;
  assign bus.mem_lo      = r_stage.lo;
  assign bus.hilo_temp_o = r_hilo_temp;
  assign bus.cnt_o       = r_cnt;
  assign bus.mem_valid   = r_valid;
`ifdef EX_MEM_LSU_EN
  assign bus.mem_aluop    = r_stage.aluop;
  assign bus.mem_mem_addr = r_stage.mem_addr;
  assign bus.mem_reg2     = r_stage.reg2;
`endif

endmodule
